// File: rtl/mix_columns_pkg.sv
// Shared AES GF(2^8) constants and helpers for the MixColumns datapath.
package mix_columns_pkg;

  localparam int unsigned STATE_W = 128;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned BYTE_W  = 8;

  localparam logic [BYTE_W-1:0] AES_RED = 8'h1B;

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? AES_RED : 8'h00);
  endfunction

  // Multiply by a small constant (up to 0x0f) via shift-and-add.
  function automatic logic [BYTE_W-1:0] gf_mul_const(input logic [BYTE_W-1:0] a,
                                                     input logic [3:0]        k);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// One AES column through MixColumns / InvMixColumns; byte s0 in bits [31:24].
module mix_single_column
  import mix_columns_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic [COL_W-1:0] col_i,
  input  logic             inverse_i,
  output logic [COL_W-1:0] col_o_c
);

  logic [BYTE_W-1:0] s0, s1, s2, s3;
  logic [BYTE_W-1:0] u, v;
  logic [BYTE_W-1:0] p0, p1, p2, p3;

  // Inverse = forward matrix applied to a column pre-multiplied by {05,00,04,00} circulant.
  always_comb begin
    s0 = col_i[31:24];
    s1 = col_i[23:16];
    s2 = col_i[15:8];
    s3 = col_i[7:0];
    u  = xtime(xtime(s0 ^ s2));
    v  = xtime(xtime(s1 ^ s3));
    p0 = s0;
    p1 = s1;
    p2 = s2;
    p3 = s3;
    if (INV_EN && inverse_i) begin
      p0 = s0 ^ u;
      p1 = s1 ^ v;
      p2 = s2 ^ u;
      p3 = s3 ^ v;
    end
    col_o_c = {gf_mul_const(p0, 4'd2) ^ gf_mul_const(p1, 4'd3) ^ p2 ^ p3,
               p0 ^ gf_mul_const(p1, 4'd2) ^ gf_mul_const(p2, 4'd3) ^ p3,
               p0 ^ p1 ^ gf_mul_const(p2, 4'd2) ^ gf_mul_const(p3, 4'd3),
               gf_mul_const(p0, 4'd3) ^ p1 ^ p2 ^ gf_mul_const(p3, 4'd2)};
  end

endmodule

// File: rtl/mix_columns.sv
// Registered AES MixColumns / InvMixColumns over a full 128-bit state.
// MSB-first row-major bytes: s[r][c] is byte 4r+c counted from the top of the vector.
module mix_columns
  import mix_columns_pkg::*;
#(
  parameter bit INV_EN = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               inverse,
  input  logic [STATE_W-1:0] state,
  output logic [STATE_W-1:0] new_state,
  output logic               out_valid
);

  logic [STATE_W-1:0] state_d;
  logic [STATE_W-1:0] state_q;
  logic               valid_q;

  // Gather column c from the four rows, mix it, scatter it back.
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [COL_W-1:0] col_in;
    logic [COL_W-1:0] col_out;

    assign col_in = {state[STATE_W-1-8*c      -: 8],
                     state[STATE_W-1-32-8*c   -: 8],
                     state[STATE_W-1-64-8*c   -: 8],
                     state[STATE_W-1-96-8*c   -: 8]};

    mix_single_column #(.INV_EN(INV_EN)) u_col (
      .col_i     (col_in),
      .inverse_i (inverse),
      .col_o_c   (col_out)
    );

    assign state_d[STATE_W-1-8*c    -: 8] = col_out[31:24];
    assign state_d[STATE_W-1-32-8*c -: 8] = col_out[23:16];
    assign state_d[STATE_W-1-64-8*c -: 8] = col_out[15:8];
    assign state_d[STATE_W-1-96-8*c -: 8] = col_out[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) state_q <= state_d;
    end
  end

  assign new_state = state_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mix_columns.sv
// Directed and round-trip checks for mix_columns, with a forward-only instance alongside.
module tb_mix_columns;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         inverse;
  logic [127:0] state;
  logic [127:0] ns;
  logic         ov;
  logic [127:0] ns_f;
  logic         ov_f;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mix_columns #(.INV_EN(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .inverse   (inverse),
    .state     (state),
    .new_state (ns),
    .out_valid (ov)
  );

  mix_columns #(.INV_EN(1'b0)) dut_fwd (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .inverse   (inverse),
    .state     (state),
    .new_state (ns_f),
    .out_valid (ov_f)
  );

  typedef struct {
    logic         inv;
    logic [127:0] st;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // Generic shift-and-add GF(2^8) product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Direct circulant-matrix reference for either direction.
  function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
    logic [7:0]   base[4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(base[2'((k - r + 4) % 4)], s[127-8*(4*k+c) -: 8]);
        o[127-8*(4*r+c) -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] x;
    logic [127:0] y;

    tbl[0] = '{1'b0, 128'hdbf201c6_130a01c6_532201c6_455c01c6,
                     128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6};
    tbl[1] = '{1'b1, 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6,
                     128'hdbf201c6_130a01c6_532201c6_455c01c6};
    tbl[2] = '{1'b0, 128'hd42d01c6_d42d01c6_d42d01c6_d52d01c6,
                     128'hd52d01c6_d52d01c6_d72d01c6_d62d01c6};
    tbl[3] = '{1'b1, 128'hd52d01c6_d52d01c6_d72d01c6_d62d01c6,
                     128'hd42d01c6_d42d01c6_d42d01c6_d52d01c6};
    tbl[4] = '{1'b0, 128'h0, 128'h0};
    tbl[5] = '{1'b1, {128{1'b1}}, {128{1'b1}}};

    // Reset held with a valid input present: nothing may be captured.
    reset    = 1'b0;
    in_valid = 1'b1;
    inverse  = 1'b0;
    state    = tbl[0].st;
    #2;
    chk("reset_state", ns, 128'h0);
    chk("reset_valid", 128'(ov), 128'd0);
    repeat (2) step();
    chk("reset_hold_state", ns, 128'h0);
    chk("reset_hold_valid", 128'(ov), 128'd0);

    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("idle_valid", 128'(ov), 128'd0);
    chk("idle_state", ns, 128'h0);

    // Back-to-back table with alternating direction.
    for (int i = 0; i < 6; i++) begin
      state    = tbl[i].st;
      inverse  = tbl[i].inv;
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_state", i), ns, tbl[i].exp);
      chk($sformatf("vec%0d_valid", i), 128'(ov), 128'd1);
      chk($sformatf("vec%0d_fwd_only", i), ns_f, model(tbl[i].st, 1'b0));
    end

    // Idle after a stream: output held, valid low.
    in_valid = 1'b0;
    state    = 128'h0123456789abcdef_fedcba9876543210;
    step();
    chk("hold_state", ns, tbl[5].exp);
    chk("hold_valid", 128'(ov), 128'd0);
    step();
    chk("hold_state2", ns, tbl[5].exp);

    // Asynchronous reset mid-stream drops the pending result.
    state    = tbl[0].st;
    inverse  = 1'b0;
    in_valid = 1'b1;
    step();
    chk("pre_rst_state", ns, tbl[0].exp);
    state = tbl[2].st;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_state", ns, 128'h0);
    chk("async_rst_valid", 128'(ov), 128'd0);
    step();
    reset    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("post_rst_state", ns, 128'h0);
    chk("post_rst_valid", 128'(ov), 128'd0);

    // Random round trips against the reference model.
    for (int i = 0; i < 8; i++) begin
      x        = {$urandom, $urandom, $urandom, $urandom};
      state    = x;
      inverse  = 1'b0;
      in_valid = 1'b1;
      step();
      chk($sformatf("rnd%0d_fwd", i), ns, model(x, 1'b0));
      chk($sformatf("rnd%0d_fwd_only", i), ns_f, model(x, 1'b0));
      y       = ns;
      state   = y;
      inverse = 1'b1;
      step();
      chk($sformatf("rnd%0d_inv_model", i), ns, model(y, 1'b1));
      chk($sformatf("rnd%0d_roundtrip", i), ns, x);
      chk($sformatf("rnd%0d_fwd_only_ignores_inv", i), ns_f, model(y, 1'b0));
    end
    in_valid = 1'b0;
    step();
    chk("final_valid", 128'(ov), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
